// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low matrix keypad scanner that reports each new press as a strobe, a key code and an LED vector.
// Build option: define KEYPAD_LED_TOGGLE_EN so each press toggles its own LED instead of loading a one-hot.
module keypad_matrix_scanner #(
  parameter int CNT_THRESHOLD = 500000,
  parameter int CNT_WIDTH     = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        keyboard_en,
  output logic [3:0]  keyboard_num,
  output logic [15:0] keyboard_led
);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_e;

  col_state_e           state, state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_end;
  logic [15:0]          key_state;
  logic [3:0]           key_base;
  logic [3:0]           press;
  logic [1:0]           press_row;
  logic [15:0]          led_next;

  function automatic logic [3:0] key_code(input logic [3:0] k);
    case (k)
      4'd0:  key_code = 4'hD;
      4'd1:  key_code = 4'hC;
      4'd2:  key_code = 4'hB;
      4'd3:  key_code = 4'hA;
      4'd4:  key_code = 4'hF;
      4'd5:  key_code = 4'h9;
      4'd6:  key_code = 4'h6;
      4'd7:  key_code = 4'h3;
      4'd8:  key_code = 4'h0;
      4'd9:  key_code = 4'h8;
      4'd10: key_code = 4'h5;
      4'd11: key_code = 4'h2;
      4'd12: key_code = 4'hE;
      4'd13: key_code = 4'h7;
      4'd14: key_code = 4'h4;
      4'd15: key_code = 4'h1;
    endcase
  endfunction

  assign cnt_end = (cnt == CNT_WIDTH'(CNT_THRESHOLD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (cnt_end) cnt <= '0;
    else              cnt <= cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COL0;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (cnt_end) begin
      case (state)
        COL0: state_next = COL1;
        COL1: state_next = COL2;
        COL2: state_next = COL3;
        COL3: state_next = COL0;
      endcase
    end
  end

  always_comb begin
    col = 4'b1110;
    case (state)
      COL0: col = 4'b1110;
      COL1: col = 4'b1101;
      COL2: col = 4'b1011;
      COL3: col = 4'b0111;
    endcase
  end

  // A key counts as a new press only if it was released at the previous sample of its column.
  assign key_base = {state, 2'b00};
  assign press    = ~row & ~key_state[key_base +: 4] & {4{cnt_end}};

  always_comb begin
    press_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (press[r]) press_row = 2'(r);
    end
  end

`ifdef KEYPAD_LED_TOGGLE_EN
  assign led_next = keyboard_led ^ (16'(press) << key_base);
`else
  assign led_next = 16'h0001 << {state, press_row};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_state    <= 16'h0000;
      keyboard_en  <= 1'b0;
      keyboard_num <= 4'h0;
      keyboard_led <= 16'h0000;
    end else begin
      keyboard_en <= |press;
      if (|press) begin
        keyboard_num <= key_code({state, press_row});
        keyboard_led <= led_next;
      end
      if (cnt_end) key_state[key_base +: 4] <= ~row;
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: a keypad model drives row from a set of held keys,
// a cycle-count reference predicts strobes, and a monitor compares every cycle.
module tb_keypad_matrix_scanner;

  localparam int THR = 5;
`ifdef KEYPAD_LED_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [3:0]  num;
    logic [15:0] led;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        keyboard_en;
  logic [3:0]  keyboard_num;
  logic [15:0] keyboard_led;

  logic [15:0] held = 16'h0000;
  int          cyc;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic [3:0]  got[$];

  // Key index k = 4*column + row, codes straight from the keypad legend.
  logic [3:0]  code_tbl [16] = '{4'hD, 4'hC, 4'hB, 4'hA, 4'hF, 4'h9, 4'h6, 4'h3,
                                 4'h0, 4'h8, 4'h5, 4'h2, 4'hE, 4'h7, 4'h4, 4'h1};

  keypad_matrix_scanner #(.CNT_THRESHOLD(THR), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .keyboard_en(keyboard_en), .keyboard_num(keyboard_num), .keyboard_led(keyboard_led)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && held[4*c+r]) row[r] = 1'b0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
    total++;
    if (actual !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", name, actual, want, cyc);
    end
  endtask

  // Reference model: column c = (cycle/THR) mod 4, sampled on the last cycle of its slot.
  logic [15:0] prev;
  logic [15:0] model_led;
  always @(negedge clk) begin
    int c, k, low;
    bit any;
    exp_t e;
    if (reset) begin
      prev = '0;
      model_led = '0;
    end else if (cyc % THR == THR - 1) begin
      c = (cyc / THR) % 4;
      any = 1'b0;
      low = 0;
      for (int r = 3; r >= 0; r--) begin
        k = 4*c + r;
        if (held[k] && !prev[k]) begin
          any = 1'b1;
          low = r;
          if (TOGGLE) model_led[k] = ~model_led[k];
        end
      end
      for (int r = 0; r < 4; r++) prev[4*c+r] = held[4*c+r];
      if (any) begin
        if (!TOGGLE) model_led = 16'(1) << (4*c + low);
        e.due = cyc + 1;
        e.num = code_tbl[4*c + low];
        e.led = model_led;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares col every cycle and pops one expectation per strobe.
  logic [3:0]  last_num;
  logic [15:0] last_led;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      last_num = 4'h0;
      last_led = 16'h0000;
    end else begin
      check("col", 32'(col), 32'(4'b1111 ^ (4'b0001 << ((cyc / THR) % 4))));
      if (keyboard_en) begin
        got.push_back(keyboard_num);
        if (exp_q.size() == 0) begin
          check("spurious_en", 32'(keyboard_en), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("en_timing", 32'(cyc), 32'(e.due));
          check("num", 32'(keyboard_num), 32'(e.num));
          check("led", 32'(keyboard_led), 32'(e.led));
          last_num = e.num;
          last_led = e.led;
        end
      end else begin
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          check("missed_en", 32'(keyboard_en), 32'd1);
          void'(exp_q.pop_front());
        end
        check("num_hold", 32'(keyboard_num), 32'(last_num));
        check("led_hold", 32'(keyboard_led), 32'(last_led));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_col", 32'(col), 32'(4'b1110));
    check("rst_en", 32'(keyboard_en), 32'd0);
    check("rst_num", 32'(keyboard_num), 32'd0);
    check("rst_led", 32'(keyboard_led), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_cyc_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_codes(input string name, input int n, input logic [15:0] codes);
    logic [3:0] want;
    check({name, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) begin
        want = codes[15-4*i -: 4];
        check(name, 32'(got[i]), 32'(want));
      end
    end
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Idle keypad: two full scans without a strobe.
    do_reset();
    wait_cyc_to(40);
    check_codes("idle", 0, 16'h0000);
    check("idle_led", 32'(keyboard_led), 32'd0);

    // Column 0 keys, one per scan.
    do_reset();
    got.delete();
    held = 16'h0001; wait_cyc_to(20);
    check_codes("c0r0", 1, 16'hD000);
    check("c0r0_led", 32'(keyboard_led), 32'h0001);
    held = 16'h0002; wait_cyc_to(40);
    held = 16'h0004; wait_cyc_to(60);
    held = 16'h0008; wait_cyc_to(80);
    check_codes("c0_rest", 3, 16'hCBA0);
    check("c0_led", 32'(keyboard_led), TOGGLE ? 32'h000F : 32'h0008);

    // Column 1 keys, then a quiet scan.
    held = 16'h0010; wait_cyc_to(100);
    held = 16'h0020; wait_cyc_to(120);
    held = 16'h0040; wait_cyc_to(140);
    held = 16'h0080; wait_cyc_to(160);
    held = 16'h0000; wait_cyc_to(200);
    check_codes("c1", 4, 16'hF963);
    check("c1_led", 32'(keyboard_led), TOGGLE ? 32'h00FF : 32'h0080);

    // Held key reports once, re-arms only after a released sample.
    held = 16'h0200; wait_cyc_to(260);
    held = 16'h0000; wait_cyc_to(280);
    held = 16'h0200; wait_cyc_to(300);
    held = 16'h0000; wait_cyc_to(320);
    check_codes("hold", 2, 16'h8800);
    check("hold_led9", 32'(keyboard_led[9]), TOGGLE ? 32'd0 : 32'd1);

    // Reset mid-slot while a key is held: fresh strobe after reset.
    held = 16'h4000; wait_cyc_to(347);
    check_codes("pre_rst", 1, 16'h4000);
    do_reset();
    wait_cyc_to(25);
    check_codes("post_rst", 1, 16'h4000);
    check("post_rst_led", 32'(keyboard_led), 32'h4000);

    // Random key activity with one reset in the middle.
    held = 16'h0000;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      @(posedge clk);
      #1;
      if ($urandom_range(7) == 0) held[$urandom_range(15)] = ~held[$urandom_range(15)];
      if ($urandom_range(31) == 0) held = 16'(1) << $urandom_range(15);
    end
    held = 16'h0000;
    repeat (3 * THR) @(posedge clk);
    #1;
    check("drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
